// File: rtl/ab_seq_driver.sv
// Self-checking stimulus driver for the two-input a/b recognizer: stores a symbol
// sequence, resets the target, plays the symbols, lets the outputs settle, then checks {y1,y2}.
module ab_seq_driver #(
    parameter int DEPTH  = 8,
    parameter int HOLD   = 1,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [1:0]                 wr_data,
    input  logic                       clr,
    input  logic                       start,
    input  logic [1:0]                 exp_y,
    input  logic                       y1_in,
    input  logic                       y2_in,
    output logic                       tgt_rst,
    output logic                       a,
    output logic                       b,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [2:0]                 state_dbg
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRST   = 3'd1,
        S_PLAY   = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [CW-1:0]   count_q;
    logic [1:0]      sym_mem [2**IW];

    logic            a_d, b_d, tgt_rst_d, busy_d, done_d, pass_d;
    logic            idle_like, last_sym, hold_end, settle_end, wr_ok;

    // Control strobes wr_en/clr/start are single-cycle level samples: each is acted on at
    // the edge where it is high, only while idle (IDLE/DONE); start beats clr beats wr_en.
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign last_sym   = (CW'(idx_q) == count_q - CW'(1));
    assign hold_end   = (tmr_q == TW'(HOLD - 1));
    assign settle_end = (tmr_q == TW'(SETTLE - 1));
    assign wr_ok      = idle_like && !start && !clr && wr_en && (count_q != CW'(DEPTH));

    assign count      = count_q;
    assign state_dbg  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            tgt_rst <= 1'b1;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            tgt_rst <= tgt_rst_d;
            a       <= a_d;
            b       <= b_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_TRST;
            end
            S_TRST: begin
                idx_d   = '0;
                tmr_d   = '0;
                state_d = (count_q == '0) ? S_SETTLE : S_PLAY;
            end
            S_PLAY: begin
                if (hold_end) begin
                    tmr_d = '0;
                    if (last_sym) state_d = S_SETTLE;
                    else          idx_d   = idx_q + IW'(1);
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    tmr_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        a_d       = 1'b0;
        b_d       = 1'b0;
        tgt_rst_d = (state_d != S_TRST);
        busy_d    = (state_d == S_TRST) || (state_d == S_PLAY) ||
                    (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d    = (state_d == S_DONE);
        pass_d    = pass;
        if (state_d == S_PLAY) {a_d, b_d} = sym_mem[idx_d];
        if (state_q == S_CHECK)     pass_d = ({y1_in, y2_in} == exp_y);
        else if (state_d == S_TRST) pass_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (idle_like && !start) begin
            if (clr)        count_q <= '0;
            else if (wr_ok) count_q <= count_q + CW'(1);
        end
    end

    // Storage needs no reset: entries at or beyond count are never played.
    always_ff @(posedge clk) begin
        if (wr_ok) sym_mem[count_q[IW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_ab_seq_driver.sv
// Bench for ab_seq_driver: two instances (HOLD=1 and HOLD=3) share stimulus; a per-cycle
// expected trace of {tgt_rst,a,b,busy,done} is queued at start and popped every cycle.
module tb_ab_seq_driver;

    localparam int DEPTH = 8;
    localparam int SET   = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MAXJ  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, clr, start;
    logic [1:0]    wr_data, exp_y;
    logic          y1_in, y2_in;

    logic          tgt_rst0, a0, b0, busy0, done0, pass0;
    logic          tgt_rst1, a1, b1, busy1, done1, pass1;
    logic [CW-1:0] count0, count1;
    logic [2:0]    state0, state1;

    int            checks = 0;
    int            errors = 0;

    logic [1:0]    mdl_buf [DEPTH];
    int            mdl_cnt = 0;
    logic [4:0]    exp_q0[$];
    logic [4:0]    exp_q1[$];

    always #5 clk = ~clk;

    ab_seq_driver #(.DEPTH(DEPTH), .HOLD(1), .SETTLE(SET)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr), .start(start),
        .exp_y(exp_y), .y1_in(y1_in), .y2_in(y2_in), .tgt_rst(tgt_rst0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .pass(pass0), .count(count0), .state_dbg(state0));

    ab_seq_driver #(.DEPTH(DEPTH), .HOLD(3), .SETTLE(SET)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr), .start(start),
        .exp_y(exp_y), .y1_in(y1_in), .y2_in(y2_in), .tgt_rst(tgt_rst1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .pass(pass1), .count(count1), .state_dbg(state1));

    // Expected {tgt_rst,a,b,busy,done} at step j after the start edge, for hold h.
    function automatic logic [4:0] trace_entry(input int h, input int j);
        if (j == 0)                    return 5'b0_00_10;
        if (j <= mdl_cnt * h)          return {1'b1, mdl_buf[(j - 1) / h], 2'b10};
        if (j <= mdl_cnt * h + SET + 1) return 5'b1_00_10;
        return 5'b1_00_01;
    endfunction

    task automatic write_sym(input logic [1:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        if (mdl_cnt < DEPTH) begin
            mdl_buf[mdl_cnt] = d;
            mdl_cnt++;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        mdl_cnt = 0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [1:0] ey, input logic [1:0] yv,
                             input bit poke);
        int j;
        logic [4:0] e;
        logic [4:0] act;
        for (int k = 0; k < 1 + mdl_cnt * 1 + SET + 2; k++) exp_q0.push_back(trace_entry(1, k));
        for (int k = 0; k < 1 + mdl_cnt * 3 + SET + 2; k++) exp_q1.push_back(trace_entry(3, k));
        @(negedge clk);
        exp_y = ey;
        {y1_in, y2_in} = yv;
        start = 1'b1;
        j = 0;
        while ((exp_q0.size() > 0 || exp_q1.size() > 0) && j < MAXJ) begin
            @(negedge clk);
            start = poke && (j == 0 || j == 1);
            wr_en = poke && (j == 0 || j == 1);
            wr_data = 2'b11;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                act = {tgt_rst0, a0, b0, busy0, done0};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s h1 step %0d: got %b want %b", nm, j, act, e);
                end
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                act = {tgt_rst1, a1, b1, busy1, done1};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s h3 step %0d: got %b want %b", nm, j, act, e);
                end
            end
            j++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (j >= MAXJ) begin
            errors++;
            $display("FAIL %s timeout: got %0d steps want < %0d", nm, j, MAXJ);
        end
        checks++;
        if ({pass0, pass1} !== {2{yv == ey}}) begin
            errors++;
            $display("FAIL %s pass: got %b%b want %b", nm, pass0, pass1, {2{yv == ey}});
        end
        checks++;
        if (count0 !== CW'(mdl_cnt) || count1 !== CW'(mdl_cnt)) begin
            errors++;
            $display("FAIL %s count: got %0d/%0d want %0d", nm, count0, count1, mdl_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({tgt_rst0, a0, b0, busy0, done0, pass0} !== 6'b100000 ||
            {tgt_rst1, a1, b1, busy1, done1, pass1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset outputs: got %b %b want 100000",
                     {tgt_rst0, a0, b0, busy0, done0, pass0}, {tgt_rst1, a1, b1, busy1, done1, pass1});
        end
        checks++;
        if (count0 !== '0 || count1 !== '0 || state0 !== 3'd0 || state1 !== 3'd0) begin
            errors++;
            $display("FAIL reset state: got cnt %0d/%0d st %0d/%0d want 0", count0, count1, state0, state1);
        end
    endtask

    task automatic test_play_match();
        write_sym(2'b10);
        write_sym(2'b01);
        checks++;
        if (count0 !== CW'(2)) begin
            errors++;
            $display("FAIL write count: got %0d want 2", count0);
        end
        run_check("play_match", 2'b10, 2'b10, 1'b0);
    endtask

    task automatic test_mismatch_replay();
        run_check("mismatch", 2'b01, 2'b10, 1'b0);
        run_check("replay", 2'b01, 2'b10, 1'b0);
    endtask

    task automatic test_full_and_clr();
        do_clr();
        for (int i = 0; i < DEPTH + 1; i++) write_sym(2'($urandom_range(0, 3)));
        checks++;
        if (count0 !== CW'(DEPTH) || count1 !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full count: got %0d/%0d want %0d", count0, count1, DEPTH);
        end
        run_check("full_play", 2'b11, 2'b11, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        wr_en = 1'b1;
        wr_data = 2'b10;
        mdl_cnt = 0;
        @(negedge clk);
        clr = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (count0 !== '0 || count1 !== '0) begin
            errors++;
            $display("FAIL clr_wr count: got %0d/%0d want 0", count0, count1);
        end
    endtask

    task automatic test_empty_run();
        run_check("empty_run", 2'b10, 2'b10, 1'b0);
    endtask

    task automatic test_busy_ignore();
        write_sym(2'b10);
        run_check("busy_ignore", 2'b00, 2'b10, 1'b1);
    endtask

    task automatic test_async_reset();
        do_clr();
        write_sym(2'b11);
        write_sym(2'b11);
        write_sym(2'b11);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        mdl_cnt = 0;
        #1;
        checks++;
        if ({tgt_rst0, a0, b0, busy0, done0} !== 5'b10000 ||
            {tgt_rst1, a1, b1, busy1, done1} !== 5'b10000) begin
            errors++;
            $display("FAIL async_rst outputs: got %b %b want 10000",
                     {tgt_rst0, a0, b0, busy0, done0}, {tgt_rst1, a1, b1, busy1, done1});
        end
        checks++;
        if (count0 !== '0 || count1 !== '0) begin
            errors++;
            $display("FAIL async_rst count: got %0d/%0d want 0", count0, count1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state0 !== 3'd0 || state1 !== 3'd0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL async_rst idle: got st %0d/%0d want 0", state0, state1);
        end
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0;
        wr_data = 2'b00;
        clr = 1'b0;
        start = 1'b0;
        exp_y = 2'b00;
        y1_in = 1'b0;
        y2_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_play_match();
        test_mismatch_replay();
        test_full_and_clr();
        test_empty_run();
        test_busy_ignore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
